unpool_2x2: RTL and testbench

- Streaming 2x2 nearest-neighbour upsampler. It is the inverse (decode) direction of the 2x2 average-pooling stage.
- Takes a pooled feature map of W x H signed 16-bit pixels in raster order. Emits a 2W x 2H map in raster order: each input pixel is replicated into its 2x2 output quad.
- Sits in the deconvolution / decoder path. Uses a single-row line buffer and valid/ready handshakes on both sides.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/unpool_2x2_if.sv | 22 ++
 rtl/line_buffer.sv | 27 ++
 rtl/unpool_2x2.sv | 176 +++++++++++++++++
 tb/tb_unpool_2x2.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN decoder-path blocks.
package cnn_pkg;

    localparam int PIXEL_W = 16;

    typedef logic signed [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVEN  = 2'd1,
        ODD   = 2'd2,
        DRAIN = 2'd3
    } unpool_state_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        cnt_w = (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unpool_2x2_if.sv
// Pixel stream bundle: input side and output side valid/ready handshakes.
interface unpool_2x2_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pixel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pixel;
    logic              out_last;

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel, out_last
    );

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel, out_last
    );
endinterface

// File: rtl/line_buffer.sv
// Single-row pixel store: synchronous write, asynchronous read, storage not reset.
module line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH  = 5,
    parameter int DATA_W = 16
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [cnt_w(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [cnt_w(DEPTH)-1:0]   raddr_i,
    output logic [DATA_W-1:0]         rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Capture the incoming row so the odd output row can replay it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/unpool_2x2.sv
// Streaming 2x2 nearest-neighbour upsampler: even output rows pass input through
// (each pixel twice), odd output rows replay the buffered row.
module unpool_2x2
    import cnn_pkg::*;
#(
    parameter int W      = 5,
    parameter int H      = 5,
    parameter int DATA_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    unpool_2x2_if.slave      bus,
    output logic             busy,
    output logic             finish
);

    localparam int             CW       = cnt_w(W);
    localparam int             RW       = cnt_w(H);
    localparam logic [CW-1:0]  COL_LAST = CW'(W - 1);
    localparam logic [CW-1:0]  COL_ONE  = CW'(1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(H - 1);
    localparam logic [RW-1:0]  ROW_ONE  = RW'(1);

    unpool_state_t     state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              phase_q, phase_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_pixel_q, out_pixel_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              finish_q, finish_d;
    logic              lb_we_s;
    logic [DATA_W-1:0] lb_rdata_s;
    logic              slot_free_s;
    logic              in_ready_s;

    line_buffer #(.DEPTH(W), .DATA_W(DATA_W)) u_line_buffer (
        .clk_i   (clk),
        .we_i    (lb_we_s),
        .waddr_i (col_q),
        .wdata_i (bus.in_pixel),
        .raddr_i (col_q),
        .rdata_o (lb_rdata_s)
    );

    // The output register may be reloaded in the same cycle it is consumed.
    assign slot_free_s = !out_valid_q || bus.out_ready;

    // Next-state, counters and output-register loads.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        phase_d     = phase_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_pixel_d = out_pixel_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        finish_d    = 1'b0;
        lb_we_s     = 1'b0;
        in_ready_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EVEN;
                    col_d   = {CW{1'b0}};
                    row_d   = {RW{1'b0}};
                    phase_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            EVEN: begin
                in_ready_s = !phase_q && slot_free_s;
                if (!phase_q) begin
                    if (bus.in_valid && in_ready_s) begin
                        out_pixel_d = bus.in_pixel;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        lb_we_s     = 1'b1;
                        phase_d     = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                    end
                end else if (slot_free_s) begin
                    // Second copy comes from the buffer entry just written.
                    out_pixel_d = lb_rdata_s;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    phase_d     = 1'b0;
                    if (col_q == COL_LAST) begin
                        col_d   = {CW{1'b0}};
                        state_d = ODD;
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end else begin
                    phase_d = 1'b1;
                end
            end
            ODD: begin
                if (slot_free_s) begin
                    out_pixel_d = lb_rdata_s;
                    out_valid_d = 1'b1;
                    out_last_d  = phase_q && (col_q == COL_LAST) && (row_q == ROW_LAST);
                    phase_d     = !phase_q;
                    if (phase_q && (col_q == COL_LAST)) begin
                        col_d = {CW{1'b0}};
                        if (row_q == ROW_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            row_d   = row_q + ROW_ONE;
                            state_d = EVEN;
                        end
                    end else if (phase_q) begin
                        col_d = col_q + COL_ONE;
                    end else begin
                        col_d = col_q;
                    end
                end else begin
                    phase_d = phase_q;
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    finish_d    = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= {CW{1'b0}};
            row_q       <= {RW{1'b0}};
            phase_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_pixel_q <= {DATA_W{1'b0}};
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pixel = out_pixel_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign finish        = finish_q;

endmodule

// File: tb/tb_unpool_2x2.sv
// Directed bench for unpool_2x2: four instances (2x2, 3x2, 5x5, 1x1) sharing stimulus,
// one selected at a time.
module tb_unpool_2x2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_pixel;
    int          sel;

    logic [3:0]  start_v;
    logic [3:0]  busy_v;
    logic [3:0]  fin_v;

    logic        o_valid, o_last, i_ready, o_busy, o_finish;
    logic [15:0] o_pixel;

    int          total = 0;
    int          bad   = 0;

    logic [15:0] pix_in [$];
    logic [15:0] got_q  [$];
    logic        last_q [$];
    int          fin_cnt, fin_t, last_hs_t, stab_err, rdy_err, timeout, hs_cnt;
    logic        end_busy;

    always #5 clk = ~clk;

    unpool_2x2_if #(.DATA_W(16)) if_a ();
    unpool_2x2_if #(.DATA_W(16)) if_b ();
    unpool_2x2_if #(.DATA_W(16)) if_c ();
    unpool_2x2_if #(.DATA_W(16)) if_d ();

    assign if_a.in_valid = in_valid; assign if_a.in_pixel = in_pixel; assign if_a.out_ready = out_ready;
    assign if_b.in_valid = in_valid; assign if_b.in_pixel = in_pixel; assign if_b.out_ready = out_ready;
    assign if_c.in_valid = in_valid; assign if_c.in_pixel = in_pixel; assign if_c.out_ready = out_ready;
    assign if_d.in_valid = in_valid; assign if_d.in_pixel = in_pixel; assign if_d.out_ready = out_ready;

    assign start_v[0] = start && (sel == 0);
    assign start_v[1] = start && (sel == 1);
    assign start_v[2] = start && (sel == 2);
    assign start_v[3] = start && (sel == 3);

    unpool_2x2 #(.W(2), .H(2), .DATA_W(16)) u_a (.clk(clk), .rst(rst), .start(start_v[0]), .bus(if_a), .busy(busy_v[0]), .finish(fin_v[0]));
    unpool_2x2 #(.W(3), .H(2), .DATA_W(16)) u_b (.clk(clk), .rst(rst), .start(start_v[1]), .bus(if_b), .busy(busy_v[1]), .finish(fin_v[1]));
    unpool_2x2 #(.W(5), .H(5), .DATA_W(16)) u_c (.clk(clk), .rst(rst), .start(start_v[2]), .bus(if_c), .busy(busy_v[2]), .finish(fin_v[2]));
    unpool_2x2 #(.W(1), .H(1), .DATA_W(16)) u_d (.clk(clk), .rst(rst), .start(start_v[3]), .bus(if_d), .busy(busy_v[3]), .finish(fin_v[3]));

    always_comb begin
        o_valid = 1'b0; o_pixel = 16'h0000; o_last = 1'b0; i_ready = 1'b0;
        o_busy = 1'b0; o_finish = 1'b0;
        case (sel)
            0: begin o_valid = if_a.out_valid; o_pixel = if_a.out_pixel; o_last = if_a.out_last; i_ready = if_a.in_ready; end
            1: begin o_valid = if_b.out_valid; o_pixel = if_b.out_pixel; o_last = if_b.out_last; i_ready = if_b.in_ready; end
            2: begin o_valid = if_c.out_valid; o_pixel = if_c.out_pixel; o_last = if_c.out_last; i_ready = if_c.in_ready; end
            3: begin o_valid = if_d.out_valid; o_pixel = if_d.out_pixel; o_last = if_d.out_last; i_ready = if_d.in_ready; end
            default: ;
        endcase
        if (sel >= 0 && sel < 4) begin
            o_busy   = busy_v[sel];
            o_finish = fin_v[sel];
        end
    end

    // Drives one frame into the selected instance and records every output beat.
    task automatic run_frame(input int w, input int n, input int rdy_mode, input int gap_mode,
                             input int abort_at, input int mid_start);
        int idx, gap, post, exp_l;
        logic prev_stall, prev_last;
        logic [15:0] prev_pix;
        got_q.delete(); last_q.delete();
        fin_cnt = 0; fin_t = -1; last_hs_t = -1; stab_err = 0; rdy_err = 0; timeout = 0; hs_cnt = 0;
        idx = 0; gap = 0; post = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_pix = 16'h0000;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (abort_at > 0 && hs_cnt >= abort_at) begin
                rst = 1'b1; in_valid = 1'b0; start = 1'b0;
                return;
            end
            start     = (t == 0) || (mid_start != 0 && t == 10);
            out_ready = (rdy_mode == 0) ? 1'b1 : ((t % 5 == 1) || (t % 5 == 4));
            if (gap > 0) begin
                in_valid = 1'b0; gap--;
            end else begin
                in_valid = (idx < n);
            end
            in_pixel = (idx < n) ? pix_in[idx] : 16'h0000;
            #1;
            if (prev_stall && (!o_valid || o_pixel !== prev_pix || o_last !== prev_last)) stab_err++;
            exp_l = 4 * w * (idx / w) + 2 * (idx % w);
            if (i_ready && (hs_cnt + int'(o_valid)) != exp_l) rdy_err++;
            if (in_valid && i_ready) begin
                idx++;
                if (gap_mode != 0) gap = 1 + (idx % 3);
            end
            if (o_valid && out_ready) begin
                got_q.push_back(o_pixel); last_q.push_back(o_last); hs_cnt++; last_hs_t = t;
            end
            if (o_finish) begin
                fin_cnt++;
                if (fin_t < 0) fin_t = t;
            end
            prev_stall = o_valid && !out_ready; prev_pix = o_pixel; prev_last = o_last;
            if (fin_t >= 0) begin
                post++;
                if (post > 3) break;
            end
        end
        if (fin_t < 0) timeout = 1;
        end_busy = o_busy;
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        sel = 0; rst = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pixel = 16'h0055;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", o_valid); end
        total++; if (o_pixel !== 16'h0000) begin bad++; $display("FAIL reset_out_pixel got=%h want=0000", o_pixel); end
        total++; if (o_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", o_last); end
        total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", i_ready); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        total++; if (o_finish !== 1'b0) begin bad++; $display("FAIL reset_finish got=%b want=0", o_finish); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL start_with_rst_busy got=%b want=0", o_busy); end
        total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL start_with_rst_in_ready got=%b want=0", i_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_basic(input int rdy_mode);
        logic [15:0] e [16] = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd2, 16'd2,
                                16'd3, 16'd3, 16'd4, 16'd4, 16'd3, 16'd3, 16'd4, 16'd4};
        logic [15:0] a;
        sel = 0; pix_in = {16'd1, 16'd2, 16'd3, 16'd4};
        run_frame(2, 4, rdy_mode, 0, 0, 0);
        total++; if (timeout != 0) begin bad++; $display("FAIL basic%0d_timeout got=%0d want=0", rdy_mode, timeout); end
        total++; if (got_q.size() != 16) begin bad++; $display("FAIL basic%0d_count got=%0d want=16", rdy_mode, got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            a = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            total++; if (a !== e[i]) begin bad++; $display("FAIL basic%0d_pix[%0d] got=%h want=%h", rdy_mode, i, a, e[i]); end
            a[0] = (i < last_q.size()) ? last_q[i] : 1'bx;
            total++; if (a[0] !== (i == 15)) begin bad++; $display("FAIL basic%0d_last[%0d] got=%b want=%b", rdy_mode, i, a[0], (i == 15)); end
        end
        total++; if (fin_cnt != 1) begin bad++; $display("FAIL basic%0d_finish_count got=%0d want=1", rdy_mode, fin_cnt); end
        total++; if (fin_t != last_hs_t + 1) begin bad++; $display("FAIL basic%0d_finish_time got=%0d want=%0d", rdy_mode, fin_t, last_hs_t + 1); end
        total++; if (end_busy !== 1'b0) begin bad++; $display("FAIL basic%0d_busy_end got=%b want=0", rdy_mode, end_busy); end
        total++; if (rdy_err != 0) begin bad++; $display("FAIL basic%0d_in_ready got=%0d want=0", rdy_mode, rdy_err); end
        total++; if (stab_err != 0) begin bad++; $display("FAIL basic%0d_stall_hold got=%0d want=0", rdy_mode, stab_err); end
    endtask

    task automatic test_signed_gaps();
        logic [15:0] e [24] = '{16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                                16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                                16'h0001, 16'h0001, 16'h7FFF, 16'h7FFF, 16'h0005, 16'h0005,
                                16'h0001, 16'h0001, 16'h7FFF, 16'h7FFF, 16'h0005, 16'h0005};
        logic [15:0] a;
        sel = 1; pix_in = {16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h7FFF, 16'h0005};
        run_frame(3, 6, 0, 1, 0, 0);
        total++; if (got_q.size() != 24) begin bad++; $display("FAIL signed_count got=%0d want=24", got_q.size()); end
        for (int i = 0; i < 24; i++) begin
            a = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            total++; if (a !== e[i]) begin bad++; $display("FAIL signed_pix[%0d] got=%h want=%h", i, a, e[i]); end
        end
        total++; if (rdy_err != 0) begin bad++; $display("FAIL signed_in_ready got=%0d want=0", rdy_err); end
        total++; if (fin_cnt != 1) begin bad++; $display("FAIL signed_finish_count got=%0d want=1", fin_cnt); end
        total++; if (last_q.size() != 24 || last_q[23] !== 1'b1) begin bad++; $display("FAIL signed_last got_size=%0d want=24 with last set", last_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] e [16] = '{16'd9, 16'd9, 16'd8, 16'd8, 16'd9, 16'd9, 16'd8, 16'd8,
                                16'd7, 16'd7, 16'd6, 16'd6, 16'd7, 16'd7, 16'd6, 16'd6};
        logic [15:0] a;
        sel = 0; pix_in = {16'd1, 16'd2, 16'd3, 16'd4};
        run_frame(2, 4, 0, 0, 5, 0);
        @(posedge clk); #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", o_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", o_busy); end
        total++; if (o_finish !== 1'b0) begin bad++; $display("FAIL midrst_finish got=%b want=0", o_finish); end
        @(negedge clk); rst = 1'b0;
        pix_in = {16'd9, 16'd8, 16'd7, 16'd6};
        run_frame(2, 4, 0, 0, 0, 0);
        total++; if (got_q.size() != 16) begin bad++; $display("FAIL midrst_count got=%0d want=16", got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            a = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            total++; if (a !== e[i]) begin bad++; $display("FAIL midrst_pix[%0d] got=%h want=%h", i, a, e[i]); end
        end
        total++; if (fin_cnt != 1) begin bad++; $display("FAIL midrst_finish_count got=%0d want=1", fin_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, x;
        int lasts;
        sel = 2; pix_in.delete();
        for (int i = 0; i < 25; i++) pix_in.push_back(16'(i + 1));
        run_frame(5, 25, 0, 0, 0, 1);
        total++; if (got_q.size() != 100) begin bad++; $display("FAIL w5_count got=%0d want=100", got_q.size()); end
        lasts = 0;
        for (int i = 0; i < 100; i++) begin
            x = 16'(((i / 10) / 2) * 5 + (i % 10) / 2 + 1);
            a = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            total++; if (a !== x) begin bad++; $display("FAIL w5_pix[%0d] got=%h want=%h", i, a, x); end
            if (i < last_q.size() && last_q[i]) lasts++;
        end
        total++; if (lasts != 1 || last_q.size() != 100 || last_q[99] !== 1'b1) begin bad++; $display("FAIL w5_last got_count=%0d want=1 on beat 99", lasts); end
        total++; if (fin_cnt != 1) begin bad++; $display("FAIL w5_finish_count got=%0d want=1", fin_cnt); end
        total++; if (end_busy !== 1'b0) begin bad++; $display("FAIL w5_busy_end got=%b want=0", end_busy); end
    endtask

    task automatic test_single();
        logic [15:0] a;
        sel = 3; pix_in = {16'h1234};
        run_frame(1, 1, 0, 0, 0, 0);
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL w1_count got=%0d want=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            a = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            total++; if (a !== 16'h1234) begin bad++; $display("FAIL w1_pix[%0d] got=%h want=1234", i, a); end
            a[0] = (i < last_q.size()) ? last_q[i] : 1'bx;
            total++; if (a[0] !== (i == 3)) begin bad++; $display("FAIL w1_last[%0d] got=%b want=%b", i, a[0], (i == 3)); end
        end
        total++; if (fin_cnt != 1) begin bad++; $display("FAIL w1_finish_count got=%0d want=1", fin_cnt); end
        total++; if (fin_t != last_hs_t + 1) begin bad++; $display("FAIL w1_finish_time got=%0d want=%0d", fin_t, last_hs_t + 1); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_pixel = 16'h0000; sel = 0;
        test_reset();
        test_basic(0);
        test_basic(1);
        test_signed_gaps();
        test_reset_mid();
        test_back_to_back();
        test_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
